sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, storage words; any integer >=2, power of two not required.
REQ-003 SHALL provide parameter FWFT, default 0; 1 = first-word-fall-through read mode, 0 = registered-read mode.
REQ-004 SHALL provide parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-005 SHALL provide parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-006 SHALL provide port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL provide port i_rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-008 SHALL provide port i_wdata, input, WIDTH, write data.
REQ-009 SHALL provide port i_wen, input, 1, write request.
REQ-010 SHALL provide port o_full, output, 1, level == DEPTH.
REQ-011 SHALL provide port o_afull, output, 1, level >= AF_LEVEL.
REQ-012 SHALL provide port i_ren, input, 1, read request.
REQ-013 SHALL provide port o_rdata, output, WIDTH, read data.
REQ-014 SHALL provide port o_empty, output, 1, level == 0.
REQ-015 SHALL provide port o_aempty, output, 1, level <= AE_LEVEL.
REQ-016 SHALL provide port o_level, output, $clog2(DEPTH+1), current stored word count.
REQ-017 SHALL provide port o_overflow, output, 1, sticky: write attempted while full.
REQ-018 SHALL provide port o_underflow, output, 1, sticky: read attempted while empty.
REQ-019 SHALL provide port i_clr_err, input, 1, synchronous clear of both sticky error flags.

Function
REQ-020 SHALL accept a write iff i_wen && !o_full; accepted word stored at write pointer, pointer advances.
REQ-021 SHALL accept a read iff i_ren && !o_empty; read pointer advances.
REQ-022 SHALL wrap both pointers from DEPTH-1 to 0; no power-of-two modulo arithmetic.
REQ-023 SHALL update level: +1 on write-only, -1 on read-only, unchanged on both or neither accepted.
REQ-024 SHALL derive o_full, o_empty, o_afull, o_aempty combinationally from the registered level; flags change the cycle after the accepting edge.
REQ-025 SHALL, when full, reject i_wen even with a simultaneous accepted read; when empty, reject i_ren even with a simultaneous write.
REQ-026 SHALL, FWFT=0: load o_rdata with the head word on an accepted read (1-cycle latency); hold o_rdata otherwise.
REQ-027 SHALL, FWFT=1: drive o_rdata = head word continuously; value valid while !o_empty; accepted read advances to the next word the following cycle.
REQ-028 SHALL set o_overflow on any edge with i_wen && o_full, and o_underflow on any edge with i_ren && o_empty.
REQ-029 SHALL clear both sticky flags on an edge with i_clr_err, except a flag whose set condition is true that same edge stays set (set wins).
REQ-030 SHALL leave memory contents and pointers unchanged by rejected requests.
REQ-031 SHALL preserve data order exactly (FIFO) across any number of wrap-arounds.

Reset
REQ-032 SHALL, on i_rst high, asynchronously clear pointers, level, o_overflow, o_underflow and (FWFT=0) o_rdata to 0; o_empty=1, o_full=0, o_aempty=1, o_afull=(AF_LEVEL==0 ? 1 : 0).
REQ-033 SHALL not reset storage memory; contents after reset are undefined and never observable before a new write.
REQ-034 SHALL discard all stored words on reset asserted mid-operation; first read after release returns the first word written after release.

Verification (WIDTH=8, DEPTH=5, AF_LEVEL=4, AE_LEVEL=1)
REQ-035 SHALL verify fill: write 0x11..0x15 -> o_level 1..5, o_afull at level 4, o_full at 5; sixth write ignored, o_overflow=1.
REQ-036 SHALL verify drain, FWFT=0: 5 reads -> o_rdata 0x11..0x15 one cycle after each read; sixth read sets o_underflow, o_rdata holds 0x15.
REQ-037 SHALL verify wrap: 12 write/read pairs through non-power-of-two depth -> data order intact, o_level never exceeds 5.
REQ-038 SHALL verify simultaneous: at level 3, i_wen and i_ren together -> level stays 3, head advances; at full, both -> only read accepted, level 4, o_overflow=1.
REQ-039 SHALL verify FWFT=1: write 0xA5 into empty -> next cycle o_empty=0, o_rdata=0xA5 with no read strobe.
REQ-040 SHALL verify reset mid-operation at level 3 and i_clr_err with simultaneous overflow -> all state zero immediately; flag stays set when set and clear coincide.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary depth, registered or first-word-fall-through
// read data, programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_wen,
    output logic                       o_full,
    output logic                       o_afull,
    input  logic                       i_ren,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic                       o_aempty,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_overflow,
    output logic                       o_underflow,
    input  logic                       i_clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_acc, rd_acc;

    assign o_full      = level_q == LW'(DEPTH);
    assign o_empty     = level_q == '0;
    assign o_afull     = level_q >= LW'(AF_LEVEL);
    assign o_aempty    = level_q <= LW'(AE_LEVEL);
    assign o_level     = level_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

    // Pointers wrap explicitly so any DEPTH works, not just powers of two.
    always_comb begin
        wr_acc   = i_wen && !o_full;
        rd_acc   = i_ren && !o_empty;
        wr_ptr_d = wr_acc ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d  = (wr_acc && !rd_acc) ? level_q + LW'(1) :
                   (rd_acc && !wr_acc) ? level_q - LW'(1) : level_q;
        ovf_d    = (i_wen && o_full) || (ovf_q && !i_clr_err);
        unf_d    = (i_ren && o_empty) || (unf_q && !i_clr_err);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; the level gates every read of it.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr_q] <= i_wdata;
    end

    if (FWFT != 0) begin : g_fwft
        assign o_rdata = mem[rd_ptr_q];
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q, rdata_d;
        always_comb rdata_d = rd_acc ? mem[rd_ptr_q] : rdata_q;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) rdata_q <= '0;
            else       rdata_q <= rdata_d;
        end
        assign o_rdata = rdata_q;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: registered-read and FWFT instances driven in lockstep and checked every
// cycle against a queue-based model, plus literal expectations for the directed scenarios.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wen = 1'b0, ren = 1'b0, clr = 1'b0;

    logic       f0, af0, e0, ae0, ov0, un0, f1, af1, e1, ae1, ov1, un1;
    logic [7:0] rd0, rd1;
    logic [2:0] lv0, lv1;

    int errs = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0] m_rd = '0;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u0 (
        .i_clk(clk), .i_rst(rst), .i_wdata(wdata), .i_wen(wen), .o_full(f0), .o_afull(af0),
        .i_ren(ren), .o_rdata(rd0), .o_empty(e0), .o_aempty(ae0), .o_level(lv0),
        .o_overflow(ov0), .o_underflow(un0), .i_clr_err(clr));

    sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_wdata(wdata), .i_wen(wen), .o_full(f1), .o_afull(af1),
        .i_ren(ren), .o_rdata(rd1), .o_empty(e1), .o_aempty(ae1), .o_level(lv1),
        .o_overflow(ov1), .o_underflow(un1), .i_clr_err(clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue of stored words, capacity 5.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd  = '0;
        end else begin
            automatic bit full  = q.size() == 5;
            automatic bit empty = q.size() == 0;
            m_ovf = (wen && full) || (m_ovf && !clr);
            m_unf = (ren && empty) || (m_unf && !clr);
            if (ren && !empty) m_rd = q.pop_front();
            if (wen && !full) q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            automatic int n = q.size();
            chk("level0", 32'(lv0), 32'(n));
            chk("level1", 32'(lv1), 32'(n));
            chk("full0", 32'(f0), 32'(n == 5));
            chk("full1", 32'(f1), 32'(n == 5));
            chk("empty0", 32'(e0), 32'(n == 0));
            chk("empty1", 32'(e1), 32'(n == 0));
            chk("afull0", 32'(af0), 32'(n >= 4));
            chk("afull1", 32'(af1), 32'(n >= 4));
            chk("aempty0", 32'(ae0), 32'(n <= 1));
            chk("aempty1", 32'(ae1), 32'(n <= 1));
            chk("ovf0", 32'(ov0), 32'(m_ovf));
            chk("ovf1", 32'(ov1), 32'(m_ovf));
            chk("unf0", 32'(un0), 32'(m_unf));
            chk("unf1", 32'(un1), 32'(m_unf));
            chk("rdata0", 32'(rd0), 32'(m_rd));
            if (n > 0) chk("rdata1_head", 32'(rd1), 32'(q[0]));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        wen = w; ren = r; clr = c; wdata = d;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(lv0), 0);
        chk("rst_empty", 32'(e0), 1);
        chk("rst_aempty", 32'(ae0), 1);
        chk("rst_full", 32'(f0), 0);
        chk("rst_afull", 32'(af0), 0);
        chk("rst_rdata", 32'(rd0), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            d = 8'h11 + 8'(i);
            cyc(1, 0, 0, d);
            chk("fill_level", 32'(lv0), 32'(i + 1));
            chk("fill_afull", 32'(af0), 32'(i >= 3));
            chk("fill_full", 32'(f0), 32'(i == 4));
        end
        cyc(1, 0, 0, 8'h99);
        chk("fill_ovf_level", 32'(lv0), 5);
        chk("fill_ovf", 32'(ov0), 1);
        cyc(0, 0, 1, 0);
        chk("clr_ovf", 32'(ov0), 0);

        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0);
            chk("drain_rdata", 32'(rd0), 32'(8'h11 + 8'(i)));
        end
        cyc(0, 1, 0, 0);
        chk("drain_unf", 32'(un0), 1);
        chk("drain_hold", 32'(rd0), 32'h15);
        cyc(0, 0, 1, 0);

        cyc(1, 0, 0, 8'h21);
        cyc(1, 0, 0, 8'h22);
        cyc(1, 0, 0, 8'h23);
        cyc(1, 1, 0, 8'h24);
        chk("simul_level", 32'(lv0), 3);
        chk("simul_rdata", 32'(rd0), 32'h21);
        cyc(1, 0, 0, 8'h25);
        cyc(1, 0, 0, 8'h26);
        cyc(1, 1, 0, 8'h27);
        chk("full_both_level", 32'(lv0), 4);
        chk("full_both_ovf", 32'(ov0), 1);
        chk("full_both_rdata", 32'(rd0), 32'h22);
        cyc(1, 0, 1, 8'h28);
        chk("clr_no_set", 32'(ov0), 0);
        cyc(1, 0, 1, 8'h29);
        chk("clr_set_wins", 32'(ov0), 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pre_rst_level", 32'(lv0), 3);

        rst = 1'b1;
        #1;
        chk("async_level", 32'(lv0), 0);
        chk("async_empty", 32'(e0), 1);
        chk("async_ovf", 32'(ov0), 0);
        chk("async_rdata", 32'(rd0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(1, 0, 0, 8'hA5);
        chk("fwft_empty", 32'(e1), 0);
        chk("fwft_rdata", 32'(rd1), 32'hA5);
        cyc(0, 1, 0, 0);
        chk("post_rst_first", 32'(rd0), 32'hA5);

        for (int i = 0; i < 12; i++) begin
            d = 8'h40 + 8'(i * 7);
            cyc(1, 0, 0, d);
            cyc(0, 1, 0, 0);
            chk("wrap_rdata", 32'(rd0), 32'(d));
        end

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 15) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
